// File: rtl/jump_ctl_pkg.sv
// Shared encodings for the jump controller: key directions, FSM states and
// the default landing watchdog length.
package jump_ctl_pkg;

  localparam logic JUMP_DIR_LEFT  = 1'b0;
  localparam logic JUMP_DIR_RIGHT = 1'b1;

  localparam int JUMP_TIMEOUT_MS = 100;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_LAND = 2'd2
  } jump_state_e;

endpackage

// File: rtl/jump_fifo.sv
// Small first-word-fall-through queue of 1-bit jump directions.
// A push into a full queue is accepted only if a pop frees a slot that cycle.
module jump_fifo #(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          din,
  input  logic          pop,
  output logic          dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/jump_ctl.sv
// Key-press to jump-command sequencer: one jump in flight at a time, with a
// landing watchdog and a saturating count of completed jumps.
//
// state        | meaning
// ST_IDLE      | no jump in flight; pops the next queued press when enabled
// ST_ISSUE     | command pulse is on the outputs; watchdog is loaded
// ST_WAIT_LAND | waiting for landed, or watchdog expiry
module jump_ctl
  import jump_ctl_pkg::*;
#(
  parameter int  FIFO_DEPTH = 4,
  parameter int  TIMEOUT_MS = JUMP_TIMEOUT_MS,
  parameter int  CNT_W      = 10,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             module_en,
  input  logic             key_left,
  input  logic             key_right,
  input  logic             one_ms_tick,
  input  logic             landed,
  output logic             jump_left,
  output logic             jump_right,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow,
  output logic             timeout_err,
  output logic [CNT_W-1:0] jump_count
);

  localparam int MS_W = $clog2(TIMEOUT_MS + 1);

  jump_state_e      state_q, state_d;
  logic [MS_W-1:0]  ms_cnt_q, ms_cnt_d;
  logic [CNT_W-1:0] jump_count_q, jump_count_d;
  logic             key_left_q, key_right_q;
  logic             jump_left_q, jump_left_d;
  logic             jump_right_q, jump_right_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;
  logic             timeout_err_q, timeout_err_d;

  logic press_left, press_right, push_req, push_dir;
  logic fifo_pop, fifo_dout, fifo_full, fifo_empty;

  assign press_left  = key_left & ~key_left_q;
  assign press_right = key_right & ~key_right_q;
  // Simultaneous presses cancel each other.
  assign push_req    = module_en & (press_left ^ press_right);
  assign push_dir    = press_right ? JUMP_DIR_RIGHT : JUMP_DIR_LEFT;
  assign fifo_pop    = module_en & (state_q == ST_IDLE) & ~fifo_empty;

  jump_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (~module_en),
    .push  (push_req),
    .din   (push_dir),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    ms_cnt_d      = ms_cnt_q;
    jump_count_d  = jump_count_q;
    timeout_err_d = timeout_err_q;
    jump_left_d   = 1'b0;
    jump_right_d  = 1'b0;
    overflow_d    = push_req & fifo_full & ~fifo_pop;
    if (!module_en) begin
      state_d       = ST_IDLE;
      timeout_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            jump_left_d  = (fifo_dout == JUMP_DIR_LEFT);
            jump_right_d = (fifo_dout == JUMP_DIR_RIGHT);
            state_d      = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          ms_cnt_d = MS_W'(TIMEOUT_MS);
          state_d  = ST_WAIT_LAND;
        end
        ST_WAIT_LAND: begin
          // landed takes priority over a coincident final watchdog tick
          if (landed) begin
            if (jump_count_q != '1) jump_count_d = jump_count_q + CNT_W'(1);
            state_d = ST_IDLE;
          end else if (one_ms_tick) begin
            if (ms_cnt_q == MS_W'(1)) begin
              timeout_err_d = 1'b1;
              state_d       = ST_IDLE;
            end
            ms_cnt_d = ms_cnt_q - MS_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ms_cnt_q      <= '0;
      jump_count_q  <= '0;
      key_left_q    <= 1'b0;
      key_right_q   <= 1'b0;
      jump_left_q   <= 1'b0;
      jump_right_q  <= 1'b0;
      busy_q        <= 1'b0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ms_cnt_q      <= ms_cnt_d;
      jump_count_q  <= jump_count_d;
      key_left_q    <= key_left;
      key_right_q   <= key_right;
      jump_left_q   <= jump_left_d;
      jump_right_q  <= jump_right_d;
      busy_q        <= busy_d;
      overflow_q    <= overflow_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign jump_left   = jump_left_q;
  assign jump_right  = jump_right_q;
  assign busy        = busy_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_err_q;
  assign jump_count  = jump_count_q;

endmodule

// File: tb/tb_jump_ctl.sv
// Directed bench for jump_ctl: latency, queueing/overflow, simultaneous keys,
// watchdog, enable flush and mid-jump reset.
module tb_jump_ctl;

  logic       clk = 1'b0;
  logic       rst_n, module_en, key_left, key_right, one_ms_tick, landed;
  logic       jump_left, jump_right, busy, overflow, timeout_err;
  logic [2:0] fifo_level;
  logic [9:0] jump_count;

  int         checks = 0;
  int         errors = 0;
  int         n_cmd = 0;
  int         n_ovf = 0;
  int         n_both = 0;
  logic [7:0] hist = '0;
  int         base_cmd, base_ovf;

  jump_ctl #(.FIFO_DEPTH(4), .TIMEOUT_MS(100), .CNT_W(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .module_en   (module_en),
    .key_left    (key_left),
    .key_right   (key_right),
    .one_ms_tick (one_ms_tick),
    .landed      (landed),
    .jump_left   (jump_left),
    .jump_right  (jump_right),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .jump_count  (jump_count)
  );

  always #5 clk = ~clk;

  // Pulse monitor; hist keeps command directions, newest in bit 0.
  always @(negedge clk) begin
    if (jump_left | jump_right) begin
      n_cmd <= n_cmd + 1;
      hist  <= {hist[6:0], jump_right};
    end
    if (overflow) n_ovf <= n_ovf + 1;
    if (jump_left & jump_right) n_both <= n_both + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic dir);
    if (dir) key_right = 1'b1; else key_left = 1'b1;
    tick();
    key_left  = 1'b0;
    key_right = 1'b0;
    tick();
  endtask

  // Press from IDLE with an empty queue; returns in WAIT_LAND.
  task automatic start_jump(input logic dir);
    if (dir) key_right = 1'b1; else key_left = 1'b1;
    tick();
    key_left  = 1'b0;
    key_right = 1'b0;
    tick();
    chk("start_pulse", {jump_right, jump_left}, dir ? 2'b10 : 2'b01);
    tick();
  endtask

  task automatic ms_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      one_ms_tick = 1'b1;
      tick();
      one_ms_tick = 1'b0;
      tick();
    end
  endtask

  task automatic land_now();
    landed = 1'b1;
    tick();
    landed = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; module_en = 1'b0; key_left = 1'b0; key_right = 1'b0;
    one_ms_tick = 1'b0; landed = 1'b0;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_cmds", {jump_left, jump_right, busy, overflow, timeout_err}, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_count", jump_count, 0);
    rst_n = 1'b1; module_en = 1'b1;
    tick();

    // Single left press: latency and landing
    key_left = 1'b1;
    tick();
    chk("lat_level_n1", fifo_level, 1);
    chk("lat_no_pulse_n1", {jump_left, jump_right, busy}, 0);
    key_left = 1'b0;
    tick();
    chk("lat_pulse_n2", {jump_left, jump_right, busy}, 3'b101);
    chk("lat_level_n2", fifo_level, 0);
    tick();
    chk("lat_pulse_n3", {jump_left, jump_right, busy}, 3'b001);
    ms_ticks(80);
    chk("no_timeout_80", timeout_err, 0);
    land_now();
    chk("land1_count", jump_count, 1);
    chk("land1_busy", busy, 0);

    // R,L,R,L,R while a left jump is in flight
    start_jump(1'b0);
    press(1'b1); press(1'b0); press(1'b1); press(1'b0);
    chk("q_full_level", fifo_level, 4);
    key_right = 1'b1;
    tick();
    chk("ovf_pulse", overflow, 1);
    chk("ovf_level", fifo_level, 4);
    key_right = 1'b0;
    tick();
    chk("ovf_one_cycle", overflow, 0);
    base_cmd = n_cmd;
    for (int k = 0; k < 4; k++) begin
      land_now();
      chk("q_busy_drop", busy, 0);
      tick();
      chk("q_cmd_dir", {jump_right, jump_left}, (k % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    land_now();
    chk("q_count", jump_count, 6);
    chk("q_busy_end", busy, 0);
    chk("q_level_end", fifo_level, 0);
    chk("q_ncmd", n_cmd - base_cmd, 4);
    chk("q_hist", hist[3:0], 4'b1010);
    chk("q_novf", n_ovf, 1);

    // Both keys in the same cycle
    base_cmd = n_cmd; base_ovf = n_ovf;
    key_left = 1'b1; key_right = 1'b1;
    tick();
    chk("both_level", fifo_level, 0);
    key_left = 1'b0; key_right = 1'b0;
    tick(); tick();
    chk("both_busy", busy, 0);
    chk("both_ncmd", n_cmd - base_cmd, 0);
    chk("both_novf", n_ovf - base_ovf, 0);

    // Watchdog expiry, then landed coinciding with the final tick
    start_jump(1'b0);
    ms_ticks(99);
    chk("wd_99_err", timeout_err, 0);
    chk("wd_99_busy", busy, 1);
    one_ms_tick = 1'b1;
    tick();
    one_ms_tick = 1'b0;
    chk("wd_err", timeout_err, 1);
    chk("wd_busy", busy, 0);
    chk("wd_count", jump_count, 6);
    tick();
    chk("wd_sticky", timeout_err, 1);
    module_en = 1'b0;
    tick();
    chk("wd_clear_on_dis", timeout_err, 0);
    module_en = 1'b1;
    tick();
    start_jump(1'b1);
    ms_ticks(99);
    one_ms_tick = 1'b1; landed = 1'b1;
    tick();
    one_ms_tick = 1'b0; landed = 1'b0;
    chk("tie_err", timeout_err, 0);
    chk("tie_count", jump_count, 7);
    chk("tie_busy", busy, 0);

    // module_en drop in WAIT_LAND with three queued
    start_jump(1'b0);
    press(1'b1); press(1'b0); press(1'b1);
    chk("dis_level_pre", fifo_level, 3);
    module_en = 1'b0;
    base_cmd = n_cmd;
    tick();
    chk("dis_level", fifo_level, 0);
    chk("dis_busy", busy, 0);
    chk("dis_count", jump_count, 7);
    key_left = 1'b1;
    tick();
    chk("dis_press_level", fifo_level, 0);
    key_left = 1'b0;
    tick();
    land_now();
    chk("dis_land_ignored", jump_count, 7);
    module_en = 1'b1;
    tick(); tick();
    chk("dis_ncmd", n_cmd - base_cmd, 0);
    chk("dis_idle", busy, 0);

    // Reset asserted on a command pulse with the queue non-empty
    start_jump(1'b0);
    press(1'b1); press(1'b0);
    land_now();
    tick();
    chk("mid_pulse", jump_right, 1);
    chk("mid_level", fifo_level, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cmds", {jump_left, jump_right, busy, overflow, timeout_err}, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_count", jump_count, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    key_left = 1'b1;
    tick();
    chk("post_rst_level", fifo_level, 1);
    key_left = 1'b0;
    tick();
    chk("post_rst_pulse", {jump_left, jump_right}, 2'b10);
    tick();
    chk("post_rst_pulse_end", {jump_left, jump_right}, 2'b00);
    chk("never_both", n_both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
